// File: rtl/spad_loader.sv
// rtl/spad_loader.sv - Host byte-stream loader for the weight/input SRAMs plus ofmap capture FIFO
// Packs bytes little-endian into SRAM words, fires route, then buffers ofmaps for the host.
module spad_loader #(
  parameter int         DATA_WIDTH      = 8,
  parameter int         SRAM_DATA_WIDTH = 64,
  parameter int         ADDR_WIDTH      = 8,
  parameter logic [1:0] WEIGHT_SRAM     = 2'd0,
  parameter logic [1:0] INPUT_SRAM      = 2'd1,
  parameter int         OUT_DEPTH       = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH:0]        i_w_count,
  input  logic [ADDR_WIDTH:0]        i_i_count,
  input  logic [15:0]                i_ofmap_count,
  input  logic [DATA_WIDTH-1:0]      i_s_data,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  output logic [SRAM_DATA_WIDTH-1:0] o_data_in,
  output logic [ADDR_WIDTH-1:0]      o_write_addr,
  output logic [1:0]                 o_spad_select,
  output logic                       o_write_en,
  output logic                       o_route_en,
  input  logic [2*DATA_WIDTH-1:0]    i_ofmap,
  input  logic                       i_ofmap_valid,
  output logic [2*DATA_WIDTH-1:0]    o_m_data,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow
);

  localparam int BYTES  = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OW     = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_I = 3'd2,
    ROUTE  = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH:0]        w_count_q, w_count_d;
  logic [ADDR_WIDTH:0]        i_count_q, i_count_d;
  logic [15:0]                ofmap_count_q, ofmap_count_d;
  logic [SRAM_DATA_WIDTH-1:0] word_q, word_d;
  logic [BIDX_W-1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [ADDR_WIDTH:0]        words_q, words_d;
  logic                       last_pending_q, last_pending_d;
  logic [SRAM_DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [ADDR_WIDTH-1:0]      write_addr_q, write_addr_d;
  logic [1:0]                 spad_select_q, spad_select_d;
  logic                       write_en_q, write_en_d;
  logic [15:0]                cap_q, cap_d;
  logic                       overflow_q, overflow_d;
  logic [PTR_W:0]             rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]             wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]              mem_q [OUT_DEPTH];
  logic [OW-1:0]              mem_d [OUT_DEPTH];

  logic                       s_ready;
  logic                       byte_acc;
  logic [ADDR_WIDTH:0]        phase_count;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       pop;
  logic                       push_req;
  logic                       push;
  logic                       done;

  always_comb begin
    state_d        = state_q;
    w_count_d      = w_count_q;
    i_count_d      = i_count_q;
    ofmap_count_d  = ofmap_count_q;
    word_d         = word_q;
    byte_idx_d     = byte_idx_q;
    addr_d         = addr_q;
    words_d        = words_q;
    last_pending_d = last_pending_q;
    data_in_d      = data_in_q;
    write_addr_d   = write_addr_q;
    spad_select_d  = spad_select_q;
    write_en_d     = 1'b0;
    cap_d          = cap_q;
    overflow_d     = overflow_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    mem_d          = mem_q;
    done           = 1'b0;

    // The last word of a phase blocks further bytes until its write cycle has gone by.
    s_ready     = ((state_q == LOAD_W) || (state_q == LOAD_I)) && !last_pending_q;
    phase_count = (state_q == LOAD_W) ? w_count_q : i_count_q;
    byte_acc    = s_ready && i_s_valid;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop        = !fifo_empty && i_m_ready;
    push_req   = (state_q == DRAIN) && i_ofmap_valid;
    push       = push_req && (!fifo_full || pop);

    if (byte_acc) begin
      word_d[byte_idx_q*DATA_WIDTH +: DATA_WIDTH] = i_s_data;
      if (byte_idx_q == BIDX_W'(BYTES - 1)) begin
        byte_idx_d   = '0;
        write_en_d   = 1'b1;
        data_in_d    = word_d;
        write_addr_d = addr_q;
        addr_d       = addr_q + 1'b1;
        words_d      = words_q + 1'b1;
        if ((words_q + 1'b1) == phase_count) begin
          last_pending_d = 1'b1;
        end
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = i_ofmap;
      wr_ptr_d                   = wr_ptr_q + 1'b1;
    end
    // Dropped values still count toward the expected total so the job can finish.
    if (push_req) begin
      cap_d = cap_q + 16'd1;
      if (!push) begin
        overflow_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          w_count_d      = i_w_count;
          i_count_d      = i_i_count;
          ofmap_count_d  = i_ofmap_count;
          overflow_d     = 1'b0;
          cap_d          = '0;
          word_d         = '0;
          byte_idx_d     = '0;
          addr_d         = '0;
          words_d        = '0;
          last_pending_d = 1'b0;
          if (i_w_count != '0) begin
            state_d       = LOAD_W;
            spad_select_d = WEIGHT_SRAM;
          end else if (i_i_count != '0) begin
            state_d       = LOAD_I;
            spad_select_d = INPUT_SRAM;
          end else begin
            state_d = ROUTE;
          end
        end
      end
      LOAD_W: begin
        if (last_pending_q) begin
          last_pending_d = 1'b0;
          addr_d         = '0;
          words_d        = '0;
          if (i_count_q != '0) begin
            state_d       = LOAD_I;
            spad_select_d = INPUT_SRAM;
          end else begin
            state_d = ROUTE;
          end
        end
      end
      LOAD_I: begin
        if (last_pending_q) begin
          last_pending_d = 1'b0;
          addr_d         = '0;
          words_d        = '0;
          state_d        = ROUTE;
        end
      end
      ROUTE: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if ((cap_q == ofmap_count_q) && fifo_empty) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= IDLE;
      w_count_q      <= '0;
      i_count_q      <= '0;
      ofmap_count_q  <= '0;
      word_q         <= '0;
      byte_idx_q     <= '0;
      addr_q         <= '0;
      words_q        <= '0;
      last_pending_q <= 1'b0;
      data_in_q      <= '0;
      write_addr_q   <= '0;
      spad_select_q  <= '0;
      write_en_q     <= 1'b0;
      cap_q          <= '0;
      overflow_q     <= 1'b0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      w_count_q      <= w_count_d;
      i_count_q      <= i_count_d;
      ofmap_count_q  <= ofmap_count_d;
      word_q         <= word_d;
      byte_idx_q     <= byte_idx_d;
      addr_q         <= addr_d;
      words_q        <= words_d;
      last_pending_q <= last_pending_d;
      data_in_q      <= data_in_d;
      write_addr_q   <= write_addr_d;
      spad_select_q  <= spad_select_d;
      write_en_q     <= write_en_d;
      cap_q          <= cap_d;
      overflow_q     <= overflow_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      mem_q          <= mem_d;
    end
  end

  assign o_s_ready     = s_ready;
  assign o_data_in     = data_in_q;
  assign o_write_addr  = write_addr_q;
  assign o_spad_select = spad_select_q;
  assign o_write_en    = write_en_q;
  assign o_route_en    = (state_q == ROUTE);
  assign o_m_data      = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign o_m_valid     = !fifo_empty;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_spad_loader.sv
// tb/tb_spad_loader.sv - Self-checking bench for spad_loader
// Random bytes/ofmaps checked against an SRAM-image and FIFO model built from the packing rules.
module tb_spad_loader;
  localparam int DW    = 8;
  localparam int SW    = 64;
  localparam int AW    = 8;
  localparam int BYTES = SW / DW;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start;
  logic [AW:0]     i_w_count, i_i_count;
  logic [15:0]     i_ofmap_count;
  logic [DW-1:0]   i_s_data;
  logic            i_s_valid;
  logic            o_s_ready;
  logic [SW-1:0]   o_data_in;
  logic [AW-1:0]   o_write_addr;
  logic [1:0]      o_spad_select;
  logic            o_write_en, o_route_en;
  logic [2*DW-1:0] i_ofmap;
  logic            i_ofmap_valid;
  logic [2*DW-1:0] o_m_data;
  logic            o_m_valid, i_m_ready;
  logic            o_busy, o_done, o_overflow;

  always #5 clk = ~clk;

  spad_loader dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start),
    .i_w_count(i_w_count), .i_i_count(i_i_count), .i_ofmap_count(i_ofmap_count),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_data_in(o_data_in), .o_write_addr(o_write_addr), .o_spad_select(o_spad_select),
    .o_write_en(o_write_en), .o_route_en(o_route_en),
    .i_ofmap(i_ofmap), .i_ofmap_valid(i_ofmap_valid),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
  );

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  wr_t             wr_log[$];
  wr_t             exp_wr[$];
  logic [2*DW-1:0] pop_log[$];
  logic [2*DW-1:0] exp_pop[$];
  logic [DW-1:0]   byte_q[$];

  logic [96:0] outs;
  assign outs = {o_s_ready, o_data_in, o_write_addr, o_spad_select, o_write_en, o_route_en,
                 o_m_data, o_m_valid, o_busy, o_done, o_overflow};

  int cyc = 0;
  int last_wr_cyc, route_cyc, done_cyc, start_cyc;
  int route_cnt = 0, done_cnt = 0, overlap_cnt = 0, stall_cnt = 0;
  int n_checks = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_write_en) begin
        wr_log.push_back({o_spad_select, o_write_addr, o_data_in});
        last_wr_cyc = cyc;
      end
      if (o_route_en) begin
        route_cnt++;
        route_cyc = cyc;
      end
      if (o_write_en && o_route_en) overlap_cnt++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_m_valid && i_m_ready) pop_log.push_back(o_m_data);
      if (o_busy && i_s_valid && !o_s_ready) stall_cnt++;
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    pop_log.delete();
    exp_pop.delete();
  endtask

  // Expected SRAM image: byte k of each word lands at bit 8k, addresses restart per phase.
  task automatic build_exp(input int nw, input int ni);
    exp_wr.delete();
    for (int p = 0; p < 2; p++) begin
      int n;
      int base;
      n    = (p == 0) ? nw : ni;
      base = (p == 0) ? 0 : nw * BYTES;
      for (int j = 0; j < n; j++) begin
        logic [SW-1:0] d;
        d = '0;
        for (int k = 0; k < BYTES; k++) d |= SW'(byte_q[base + j*BYTES + k]) << (DW*k);
        exp_wr.push_back({(p == 0) ? 2'd0 : 2'd1, AW'(j), d});
      end
    end
  endtask

  task automatic fill_bytes(input int n, input bit rnd);
    byte_q.delete();
    for (int k = 0; k < n; k++) byte_q.push_back(rnd ? DW'($urandom) : DW'(k));
  endtask

  task automatic start_job(input int w, input int ni, input int ofm);
    i_w_count     = (AW+1)'(w);
    i_i_count     = (AW+1)'(ni);
    i_ofmap_count = 16'(ofm);
    i_start       = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_bytes(input int gap_pct, input int start_at);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < byte_q.size() && ok; k++) begin
      int  t;
      bit  acc;
      if (gap_pct > 0 && (k % BYTES) != 0) begin
        int g;
        g = 0;
        while (g < 5 && $urandom_range(99) < gap_pct) begin
          i_s_valid = 1'b0;
          @(posedge clk); #1;
          g++;
        end
      end
      i_s_data  = byte_q[k];
      i_s_valid = 1'b1;
      i_start   = (k == start_at);
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 100) begin
        @(negedge clk);
        acc = o_s_ready;
        @(posedge clk); #1;
        i_start = 1'b0;
        t++;
      end
      if (!acc) ok = 1'b0;
    end
    i_s_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL byte_accept: stream stalled, got ready=0 expected all %0d bytes accepted", byte_q.size());
    end
  endtask

  task automatic wait_route();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      seen = o_route_en;
    end
    @(posedge clk); #1;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL route_wait: got no o_route_en expected one pulse");
    end
  endtask

  task automatic deliver_ofmaps(input int n, input int start_at, input int keep);
    for (int k = 0; k < n; k++) begin
      i_ofmap       = 16'($urandom);
      i_ofmap_valid = 1'b1;
      i_start       = (k == start_at);
      if (k < keep) exp_pop.push_back(i_ofmap);
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    i_ofmap_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      seen = o_done;
    end
    @(posedge clk); #1;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_wait: got no o_done expected one pulse");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_stream_basic();
    int d0, r0, s0;
    clear_logs();
    i_m_ready = 1'b1;
    fill_bytes(24, 1'b0);
    build_exp(2, 1);
    d0 = done_cnt; r0 = route_cnt; s0 = stall_cnt;
    start_job(2, 1, 3);
    send_bytes(0, -1);
    wait_route();
    deliver_ofmaps(3, -1, 3);
    wait_done();
    n_checks++;
    if (wr_log.size() !== 3) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d expected 3", wr_log.size());
    end
    for (int j = 0; j < wr_log.size() && j < exp_wr.size(); j++) begin
      n_checks++;
      if (wr_log[j] !== exp_wr[j]) begin
        n_fail++;
        $display("FAIL basic_write%0d: got %h expected %h", j, wr_log[j], exp_wr[j]);
      end
    end
    if (wr_log.size() > 0) begin
      n_checks++;
      if (wr_log[0].data !== 64'h0706050403020100) begin
        n_fail++;
        $display("FAIL basic_word0: got %h expected 0706050403020100", wr_log[0].data);
      end
    end
    n_checks++;
    if (route_cyc !== last_wr_cyc + 1 || route_cnt - r0 !== 1) begin
      n_fail++;
      $display("FAIL basic_route: got cycle %0d count %0d expected cycle %0d count 1",
               route_cyc, route_cnt - r0, last_wr_cyc + 1);
    end
    n_checks++;
    if (stall_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL basic_stalls: got %0d expected 1", stall_cnt - s0);
    end
    n_checks++;
    if (pop_log !== exp_pop) begin
      n_fail++;
      $display("FAIL basic_ofmaps: got %p expected %p", pop_log, exp_pop);
    end
    n_checks++;
    if (done_cnt - d0 !== 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got %0d busy %b expected 1 busy 0", done_cnt - d0, o_busy);
    end
  endtask

  task automatic test_stream_gaps();
    int s0;
    clear_logs();
    fill_bytes(24, 1'b0);
    build_exp(2, 1);
    s0 = stall_cnt;
    start_job(2, 1, 3);
    send_bytes(40, -1);
    wait_route();
    deliver_ofmaps(3, -1, 3);
    wait_done();
    n_checks++;
    if (wr_log !== exp_wr) begin
      n_fail++;
      $display("FAIL gaps_image: got %p expected %p", wr_log, exp_wr);
    end
    n_checks++;
    if (stall_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL gaps_boundary_stall: got %0d expected 1", stall_cnt - s0);
    end
    n_checks++;
    if (route_cyc !== last_wr_cyc + 1) begin
      n_fail++;
      $display("FAIL gaps_route: got %0d expected %0d", route_cyc, last_wr_cyc + 1);
    end
    n_checks++;
    if (pop_log !== exp_pop) begin
      n_fail++;
      $display("FAIL gaps_ofmaps: got %p expected %p", pop_log, exp_pop);
    end
  endtask

  task automatic test_zero_counts();
    int d0, r0;
    clear_logs();
    d0 = done_cnt; r0 = route_cnt;
    start_job(0, 0, 0);
    wait_done();
    n_checks++;
    if (route_cnt - r0 !== 1 || route_cyc !== start_cyc + 1) begin
      n_fail++;
      $display("FAIL zero_route: got cycle %0d count %0d expected cycle %0d count 1",
               route_cyc, route_cnt - r0, start_cyc + 1);
    end
    n_checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== start_cyc + 2) begin
      n_fail++;
      $display("FAIL zero_done: got cycle %0d count %0d expected cycle %0d count 1",
               done_cyc, done_cnt - d0, start_cyc + 2);
    end
    n_checks++;
    if (wr_log.size() !== 0) begin
      n_fail++;
      $display("FAIL zero_writes: got %0d expected 0", wr_log.size());
    end
  endtask

  task automatic test_overflow();
    int d0;
    clear_logs();
    i_m_ready = 1'b0;
    d0 = done_cnt;
    start_job(0, 0, 12);
    wait_route();
    deliver_ofmaps(12, -1, DEPTH);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_overflow !== 1'b1 || o_m_valid !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: got ovf %b valid %b busy %b expected 1 1 1", o_overflow, o_m_valid, o_busy);
    end
    n_checks++;
    if (done_cnt - d0 !== 0) begin
      n_fail++;
      $display("FAIL ovf_early_done: got %0d expected 0", done_cnt - d0);
    end
    i_m_ready = 1'b1;
    wait_done();
    n_checks++;
    if (pop_log !== exp_pop) begin
      n_fail++;
      $display("FAIL ovf_kept: got %p expected %p", pop_log, exp_pop);
    end
    n_checks++;
    if (o_overflow !== 1'b1 || done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf %b done %0d expected 1 1", o_overflow, done_cnt - d0);
    end
    start_job(0, 0, 0);
    n_checks++;
    if (o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", o_overflow);
    end
    wait_done();
  endtask

  task automatic test_reset_mid_job();
    int r0;
    clear_logs();
    fill_bytes(5, 1'b1);
    start_job(2, 1, 3);
    send_bytes(0, -1);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h expected 0", outs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    r0 = route_cnt;
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (wr_log.size() !== 0 || route_cnt - r0 !== 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got writes %0d routes %0d busy %b expected 0 0 0",
               wr_log.size(), route_cnt - r0, o_busy);
    end
    fill_bytes(8, 1'b1);
    build_exp(1, 0);
    start_job(1, 0, 1);
    send_bytes(20, -1);
    wait_route();
    deliver_ofmaps(1, -1, 1);
    wait_done();
    n_checks++;
    if (wr_log !== exp_wr) begin
      n_fail++;
      $display("FAIL rst_fresh_job: got %p expected %p", wr_log, exp_wr);
    end
  endtask

  task automatic test_start_ignored();
    int d0, r0;
    clear_logs();
    fill_bytes(16, 1'b1);
    build_exp(1, 1);
    d0 = done_cnt; r0 = route_cnt;
    start_job(1, 1, 2);
    i_w_count     = 9'd3;
    i_i_count     = 9'd5;
    i_ofmap_count = 16'd9;
    send_bytes(0, 10);
    wait_route();
    deliver_ofmaps(2, 1, 2);
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (wr_log !== exp_wr) begin
      n_fail++;
      $display("FAIL ign_image: got %p expected %p", wr_log, exp_wr);
    end
    n_checks++;
    if (done_cnt - d0 !== 1 || route_cnt - r0 !== 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_single_job: got done %0d route %0d busy %b expected 1 1 0",
               done_cnt - d0, route_cnt - r0, o_busy);
    end
    n_checks++;
    if (pop_log !== exp_pop) begin
      n_fail++;
      $display("FAIL ign_ofmaps: got %p expected %p", pop_log, exp_pop);
    end
    n_checks++;
    if (overlap_cnt !== 0) begin
      n_fail++;
      $display("FAIL write_route_overlap: got %0d expected 0", overlap_cnt);
    end
  endtask

  initial begin
    rst           = 1'b1;
    i_start       = 1'b0;
    i_w_count     = '0;
    i_i_count     = '0;
    i_ofmap_count = '0;
    i_s_data      = '0;
    i_s_valid     = 1'b0;
    i_ofmap       = '0;
    i_ofmap_valid = 1'b0;
    i_m_ready     = 1'b0;
    test_reset();
    test_stream_basic();
    test_stream_gaps();
    test_zero_counts();
    test_overflow();
    test_reset_mid_job();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
